i2c_apb_seq: RTL and testbench

// - APB master sitting directly upstream of the i2c_top APB slave port. It turns one client transfer command
//   (slave address, direction, length) into the APB register accesses that run one complete I2C transaction.
// - Write command: pushes address + payload into the TX FIFO, then polls SR until the bus is idle.
// - Read command: pushes address + byte count, then polls RX occupancy and drains RX_FIFO to the client.

---
 rtl/i2c_apb_seq.sv | 263 ++++++++++++++++++++++++++
 tb/tb_i2c_apb_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_apb_seq.sv
`default_nettype none
// ============================================================================
// Module      : i2c_apb_seq
// Description : APB master that turns one client transfer command (slave
//               address, direction, length) into the i2c_top register
//               accesses for one complete I2C transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_apb_seq #(
  parameter logic [31:0] ADR_SR     = 32'h104,
  parameter logic [31:0] ADR_TXFIFO = 32'h108,
  parameter logic [31:0] ADR_RXFIFO = 32'h10C,
  parameter logic [31:0] ADR_RXOCY  = 32'h118,
  parameter int          SR_BB_BIT  = 2,
  parameter int          SR_TXE_BIT = 7,
  parameter int          TO_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_adr,
  input  logic [3:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        err,
  output logic        apb_sel,
  output logic        apb_en,
  output logic        apb_write,
  output logic [31:0] apb_addr,
  output logic [31:0] apb_wdata,
  input  logic        apb_ready,
  input  logic [31:0] apb_rdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ADR   = 3'd1,
    S_WR_DAT   = 3'd2,
    S_RD_LEN   = 3'd3,
    S_POLL_SR  = 3'd4,
    S_POLL_OCY = 3'd5,
    S_RD_POP   = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic              r_sel;
  logic              r_en;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [6:0]        r_adr;
  logic              r_rw;
  logic [3:0]        r_len;
  logic [3:0]        r_rem;
  logic [7:0]        r_byte;
  logic              r_have;
  logic [TO_W-1:0]   r_to;
  logic              r_err;
  logic              r_done;
  logic              r_err_o;
  logic              r_rd_valid;
  logic [7:0]        r_rd_data;

  logic              w_acc;
  logic              w_xdone;
  logic              w_start;
  logic              w_write;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic              w_wr_take;
  logic              w_to_fire;
  logic [TO_W-1:0]   w_to_inc;
  logic              w_to_hit;
  logic              w_sr_ok;
  logic              w_ocy_nz;
  logic              w_last;
  logic              w_poll_entry;
  logic              w_unused;

  assign w_acc     = cmd_valid & cmd_ready;
  assign w_xdone   = r_sel & r_en & apb_ready;
  assign w_to_inc  = r_to + {{(TO_W-1){1'b0}}, 1'b1};
  assign w_to_hit  = &w_to_inc;
  assign w_sr_ok   = apb_rdata[SR_TXE_BIT] & ~apb_rdata[SR_BB_BIT];
  assign w_ocy_nz  = |apb_rdata[4:0];
  assign w_last    = (r_rem == 4'd1);
  assign w_unused  = &{1'b0, apb_rdata[31:8]};
  assign w_poll_entry = (w_nxt != r_state) && ((w_nxt == S_POLL_SR) || (w_nxt == S_POLL_OCY));

  // Command is only taken in IDLE, and not while the done pulse is still out
  assign cmd_ready = (r_state == S_IDLE) & ~r_done;
  assign wr_ready  = w_wr_take;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign done      = r_done;
  assign err       = r_err_o;
  assign apb_sel   = r_sel;
  assign apb_en    = r_en;
  assign apb_write = r_write;
  assign apb_addr  = r_addr;
  assign apb_wdata = r_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Next state plus the APB request for the access owned by the current state
  always_comb begin
    w_nxt     = r_state;
    w_start   = 1'b0;
    w_write   = 1'b0;
    w_addr    = 32'h0;
    w_wdata   = 32'h0;
    w_wr_take = 1'b0;
    w_to_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) w_nxt = (cmd_len == 4'd0) ? S_DONE : S_WR_ADR;
      end
      S_WR_ADR: begin
        w_start = ~r_sel;
        w_write = 1'b1;
        w_addr  = ADR_TXFIFO;
        w_wdata = {22'b0, 1'b0, 1'b1, r_adr, r_rw};
        if (w_xdone) w_nxt = r_rw ? S_RD_LEN : S_WR_DAT;
      end
      S_WR_DAT: begin
        // A byte is taken only while no push is in flight
        w_wr_take = ~r_sel & ~r_have & wr_valid;
        w_start   = ~r_sel & r_have;
        w_write   = 1'b1;
        w_addr    = ADR_TXFIFO;
        w_wdata   = {22'b0, w_last, 1'b0, r_byte};
        if (w_xdone && w_last) w_nxt = S_POLL_SR;
      end
      S_RD_LEN: begin
        w_start = ~r_sel;
        w_write = 1'b1;
        w_addr  = ADR_TXFIFO;
        w_wdata = {22'b0, 1'b1, 1'b0, 4'b0, r_len};
        if (w_xdone) w_nxt = S_POLL_OCY;
      end
      S_POLL_SR: begin
        w_start = ~r_sel;
        w_addr  = ADR_SR;
        if (w_xdone) begin
          if (w_sr_ok) begin
            w_nxt = S_DONE;
          end else if (w_to_hit) begin
            w_nxt     = S_DONE;
            w_to_fire = 1'b1;
          end
        end
      end
      S_POLL_OCY: begin
        w_start = ~r_sel;
        w_addr  = ADR_RXOCY;
        if (w_xdone) begin
          if (w_ocy_nz) begin
            w_nxt = S_RD_POP;
          end else if (w_to_hit) begin
            w_nxt     = S_DONE;
            w_to_fire = 1'b1;
          end
        end
      end
      S_RD_POP: begin
        w_start = ~r_sel;
        w_addr  = ADR_RXFIFO;
        if (w_xdone) w_nxt = w_last ? S_DONE : S_POLL_OCY;
      end
      S_DONE: begin
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // APB phase sequencing: request -> SETUP -> ACCESS until ready -> idle gap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel   <= 1'b0;
      r_en    <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else if (w_start) begin
      r_sel   <= 1'b1;
      r_en    <= 1'b0;
      r_write <= w_write;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end else if (r_sel && !r_en) begin
      r_en    <= 1'b1;
    end else if (w_xdone) begin
      r_sel   <= 1'b0;
      r_en    <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end
  end

  // Command context, payload byte, byte counter, poll timeout and client outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr      <= 7'h0;
      r_rw       <= 1'b0;
      r_len      <= 4'h0;
      r_rem      <= 4'h0;
      r_byte     <= 8'h0;
      r_have     <= 1'b0;
      r_to       <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_err_o    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h0;
    end else begin
      if (w_acc) begin
        r_adr <= cmd_adr;
        r_rw  <= cmd_rw;
        r_len <= cmd_len;
        r_rem <= cmd_len;
        r_err <= (cmd_len == 4'd0);
      end
      if (w_wr_take) begin
        r_byte <= wr_data;
        r_have <= 1'b1;
      end
      if (w_xdone && (r_state == S_WR_DAT)) begin
        r_have <= 1'b0;
        r_rem  <= r_rem - 4'd1;
      end
      r_rd_valid <= 1'b0;
      if (w_xdone && (r_state == S_RD_POP)) begin
        r_rem      <= r_rem - 4'd1;
        r_rd_valid <= 1'b1;
        r_rd_data  <= apb_rdata[7:0];
      end
      if (w_poll_entry) begin
        r_to <= '0;
      end else if (w_xdone && ((r_state == S_POLL_SR) || (r_state == S_POLL_OCY))) begin
        r_to <= w_to_inc;
      end
      if (w_to_fire) r_err <= 1'b1;
      r_done  <= (r_state == S_DONE);
      r_err_o <= (r_state == S_DONE) & r_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_apb_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_apb_seq
// Description : Self-checking bench for i2c_apb_seq with an APB slave model
//               and scoreboard queues for TX pushes and read bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_apb_seq;

  localparam logic [31:0] C_ADR_SR     = 32'h104;
  localparam logic [31:0] C_ADR_TXFIFO = 32'h108;
  localparam logic [31:0] C_ADR_RXFIFO = 32'h10C;
  localparam logic [31:0] C_ADR_RXOCY  = 32'h118;
  localparam int          C_TO_W       = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [6:0]  cmd_adr;
  logic [3:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        done;
  logic        err;
  logic        apb_sel;
  logic        apb_en;
  logic        apb_write;
  logic [31:0] apb_addr;
  logic [31:0] apb_wdata;
  logic        apb_ready;
  logic [31:0] apb_rdata;

  i2c_apb_seq #(
    .ADR_SR     (C_ADR_SR),
    .ADR_TXFIFO (C_ADR_TXFIFO),
    .ADR_RXFIFO (C_ADR_RXFIFO),
    .ADR_RXOCY  (C_ADR_RXOCY),
    .SR_BB_BIT  (2),
    .SR_TXE_BIT (7),
    .TO_W       (C_TO_W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_adr   (cmd_adr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .err       (err),
    .apb_sel   (apb_sel),
    .apb_en    (apb_en),
    .apb_write (apb_write),
    .apb_addr  (apb_addr),
    .apb_wdata (apb_wdata),
    .apb_ready (apb_ready),
    .apb_rdata (apb_rdata)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard queues and slave model state
  logic [31:0] exp_push[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  wr_q[$];
  logic [31:0] sr_q[$];
  logic [31:0] ocy_q[$];
  logic [31:0] sr_def;
  int          wait_cycles;
  int          wait_cnt;
  int          acc_cycles;
  int          ncyc = 0;
  int          xfer_cnt = 0;
  int          push_cnt = 0;
  int          sr_reads = 0;
  int          done_cnt = 0;
  int          done_ncyc = 0;
  int          acc_ncyc = 0;
  logic        done_err;
  logic        acc_seen;
  logic        wr_take;
  logic        prev_xfer;
  logic        prev_done;
  logic        rdy_at_done;
  logic        rdy_after;
  logic        last_ocy_nz;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_write;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // APB slave model and output monitor, evaluated mid-cycle
  initial begin
    logic [31:0] v;
    apb_ready   = 1'b0;
    apb_rdata   = 32'h0;
    acc_seen    = 1'b0;
    wr_take     = 1'b0;
    prev_xfer   = 1'b0;
    prev_done   = 1'b0;
    last_ocy_nz = 1'b0;
    wait_cnt    = 0;
    acc_cycles  = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      apb_ready = 1'b0;
      apb_rdata = 32'h0;
      if (rst) begin
        prev_xfer = 1'b0;
      end else begin
        if (prev_xfer) check_val("apb_gap", {30'b0, apb_sel, apb_en}, 32'h0);
        prev_xfer = 1'b0;
        if (apb_sel && !apb_en) begin
          cap_addr   = apb_addr;
          cap_wdata  = apb_wdata;
          cap_write  = apb_write;
          wait_cnt   = 0;
          acc_cycles = 0;
          xfer_cnt++;
          if (!apb_write) check_val("rd_wdata_zero", apb_wdata, 32'h0);
        end else if (apb_sel && apb_en) begin
          check_val("hold_addr", apb_addr, cap_addr);
          check_val("hold_wdata", apb_wdata, cap_wdata);
          check_val("hold_write", {31'b0, apb_write}, {31'b0, cap_write});
          acc_cycles++;
          if (wait_cnt < wait_cycles) begin
            wait_cnt++;
          end else begin
            apb_ready = 1'b1;
            prev_xfer = 1'b1;
            check_val("acc_len", acc_cycles, wait_cycles + 1);
            if (apb_write) begin
              check_val("wr_addr", apb_addr, C_ADR_TXFIFO);
              push_cnt++;
              if (exp_push.size() != 0) begin
                v = exp_push.pop_front();
                check_val("tx_push", apb_wdata, v);
              end else begin
                check_val("tx_push_unexp", apb_wdata, 32'hFFFF_FFFF);
              end
            end else if (apb_addr == C_ADR_SR) begin
              sr_reads++;
              apb_rdata = (sr_q.size() != 0) ? sr_q.pop_front() : sr_def;
            end else if (apb_addr == C_ADR_RXOCY) begin
              apb_rdata   = (ocy_q.size() != 0) ? ocy_q.pop_front() : rx_q.size();
              last_ocy_nz = (apb_rdata[4:0] != 5'd0);
            end else if (apb_addr == C_ADR_RXFIFO) begin
              check_val("pop_after_ocy", {31'b0, last_ocy_nz}, 32'h1);
              last_ocy_nz = 1'b0;
              if (rx_q.size() != 0) apb_rdata = {24'b0, rx_q.pop_front()};
              else check_val("rx_underflow", rx_q.size(), 32'h1);
            end else begin
              check_val("rd_addr", apb_addr, C_ADR_SR);
            end
          end
        end
        if (cmd_valid && cmd_ready) begin
          acc_seen = 1'b1;
          acc_ncyc = ncyc;
        end
        if (wr_valid && wr_ready) wr_take = 1'b1;
      end
      if (rd_valid) begin
        if (exp_rd.size() != 0) check_val("rd_data", {24'b0, rd_data}, {24'b0, exp_rd.pop_front()});
        else check_val("rd_unexp", {24'b0, rd_data}, 32'hFFFF_FFFF);
      end
      if (prev_done) rdy_after = cmd_ready;
      if (done) begin
        done_cnt++;
        done_err    = err;
        done_ncyc   = ncyc;
        rdy_at_done = cmd_ready;
      end
      prev_done = done;
    end
  end

  // Payload feeder: presents the head of wr_q, pops it after each handshake
  initial begin
    logic [7:0] d;
    wr_valid = 1'b0;
    wr_data  = 8'h0;
    forever begin
      @(posedge clk);
      #1;
      if (wr_take) begin
        if (wr_q.size() != 0) d = wr_q.pop_front();
        wr_take = 1'b0;
      end
      wr_valid = (wr_q.size() != 0);
      wr_data  = (wr_q.size() != 0) ? wr_q[0] : 8'h0;
    end
  end

  task automatic send_cmd(input logic rw, input logic [6:0] adr, input logic [3:0] len);
    acc_seen  = 1'b0;
    cmd_rw    = rw;
    cmd_adr   = adr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc_seen; i++) begin
      @(posedge clk);
      #1;
    end
    check_val("cmd_accept", {31'b0, acc_seen}, 32'h1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input logic exp_err);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < maxc && done_cnt == d0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("done_count", done_cnt - d0, 32'h1);
    check_val("done_err", {31'b0, done_err}, {31'b0, exp_err});
    check_val("rdy_at_done", {31'b0, rdy_at_done}, 32'h0);
    check_val("rdy_after_done", {31'b0, rdy_after}, 32'h1);
    check_val("push_left", exp_push.size(), 32'h0);
    check_val("rd_left", exp_rd.size(), 32'h0);
  endtask

  initial begin
    int x0;
    int d0;
    int p0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_rw = 1'b0;
    cmd_adr = 7'h0;
    cmd_len = 4'h0;
    wait_cycles = 0;
    sr_def = 32'h80;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_apb_ctl", {29'b0, apb_sel, apb_en, apb_write}, 32'h0);
    check_val("rst_addr", apb_addr, 32'h0);
    check_val("rst_wdata", apb_wdata, 32'h0);
    check_val("rst_outs", {28'b0, done, err, rd_valid, wr_ready}, 32'h0);
    check_val("rst_rd_data", {24'b0, rd_data}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("idle_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Write 0x50, two bytes, SR busy for a few polls
    exp_push = '{32'h1A0, 32'h0A5, 32'h23C};
    wr_q     = '{8'hA5, 8'h3C};
    sr_q     = '{32'h04, 32'h00, 32'h84};
    sr_reads = 0;
    send_cmd(1'b0, 7'h50, 4'd2);
    wait_done(300, 1'b0);
    check_val("wr_sr_reads", sr_reads, 32'd4);

    // Read 0x50, three bytes, occupancy empty twice first
    exp_push = '{32'h1A1, 32'h203};
    ocy_q    = '{32'h0, 32'h0};
    rx_q     = '{8'h11, 8'h22, 8'h33};
    exp_rd   = '{8'h11, 8'h22, 8'h33};
    send_cmd(1'b1, 7'h50, 4'd3);
    wait_done(300, 1'b0);
    check_val("rx_left", rx_q.size(), 32'h0);

    // Zero length: no bus traffic, error done two cycles after acceptance
    x0 = xfer_cnt;
    send_cmd(1'b0, 7'h50, 4'd0);
    wait_done(20, 1'b1);
    check_val("len0_latency", done_ncyc - acc_ncyc, 32'd2);
    check_val("len0_xfers", xfer_cnt - x0, 32'd0);

    // Slave inserts five wait states on every access
    wait_cycles = 5;
    exp_push = '{32'h178, 32'h25A};
    wr_q     = '{8'h5A};
    send_cmd(1'b0, 7'h3C, 4'd1);
    wait_done(300, 1'b0);
    wait_cycles = 0;

    // SR never idle: timeout after 2**TO_W-1 polls
    sr_def   = 32'h84;
    sr_reads = 0;
    exp_push = '{32'h1A0, 32'h277};
    wr_q     = '{8'h77};
    send_cmd(1'b0, 7'h50, 4'd1);
    wait_done(400, 1'b1);
    check_val("to_sr_reads", sr_reads, 32'd15);
    sr_def = 32'h80;

    // Reset in the middle of the payload
    exp_push = '{32'h1A0, 32'h011, 32'h022};
    wr_q     = '{8'h11, 8'h22, 8'h33};
    p0 = push_cnt;
    send_cmd(1'b0, 7'h50, 4'd3);
    for (int i = 0; i < 200 && (push_cnt - p0) < 2; i++) begin
      @(posedge clk);
      #1;
    end
    check_val("rst_reach_byte1", push_cnt - p0, 32'd2);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_mid_sel_en", {30'b0, apb_sel, apb_en}, 32'h0);
    check_val("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_push.delete();
    wr_q.delete();
    repeat (20) @(posedge clk);
    #1;
    check_val("rst_no_done", done_cnt - d0, 32'd0);

    // Recovery: single-byte read after the abandoned transfer
    exp_push = '{32'h143, 32'h201};
    rx_q     = '{8'h9C};
    exp_rd   = '{8'h9C};
    send_cmd(1'b1, 7'h21, 4'd1);
    wait_done(300, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
